// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - JK operation encoding shared by the counter and its cells.
package jk_pkg;

    // Enum bits are laid out as {j, k}, so an op can be split straight onto the cell pins.
    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_op_t;

    // Incremental step: flip only the bits that change.
    function automatic jk_op_t jk_encode(input logic cur, input logic nxt);
        return (cur != nxt) ? JK_TOGGLE : JK_HOLD;
    endfunction

    // Absolute write, used for load, preset and wrap.
    function automatic jk_op_t jk_force(input logic nxt);
        return nxt ? JK_SET : JK_RESET;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop with synchronous active-high clear.
module jk_cell (
    input  logic clk,
    input  logic clr,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qn
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        case ({j, k})
            2'b01:   q_d = 1'b0;
            2'b10:   q_d = 1'b1;
            2'b11:   q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign qn = ~q_q;

endmodule

// File: rtl/jk_updown_counter.sv
// rtl/jk_updown_counter.sv - up/down modulo counter on a bank of jk_cell flops.
// Build option: JK_CNT_SATURATE_EN selects saturating limits instead of wrap-around.
module jk_updown_counter
    import jk_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int MODULUS    = 16,
    parameter int PRESET_VAL = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] PRESET_V = WIDTH'(PRESET_VAL);
    // One extra bit so MODULUS == 2**WIDTH is representable in range checks.
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] j_v;
    logic [WIDTH-1:0] k_v;
    logic             force_sr;
    logic             at_max;
    logic             at_zero;
    logic             out_rng;

    always_comb begin
        at_max   = (q == MAX_V);
        at_zero  = (q == '0);
        out_rng  = ({1'b0, q} >= MOD_EXT);
        nxt      = q;
        force_sr = 1'b0;

        if (pr) begin
            nxt      = PRESET_V;
            force_sr = 1'b1;
        end else if (load) begin
            nxt      = ({1'b0, d} < MOD_EXT) ? d : MAX_V;
            force_sr = 1'b1;
        end else if (en) begin
            if (up) begin
`ifdef JK_CNT_SATURATE_EN
                if (at_max || out_rng) begin
                    nxt      = MAX_V;
                    force_sr = 1'b1;
                end else begin
                    nxt = q + 1'b1;
                end
`else
                if (at_max || out_rng) begin
                    nxt      = '0;
                    force_sr = 1'b1;
                end else begin
                    nxt = q + 1'b1;
                end
`endif
            end else begin
`ifdef JK_CNT_SATURATE_EN
                if (out_rng) begin
                    nxt      = MAX_V;
                    force_sr = 1'b1;
                end else if (!at_zero) begin
                    nxt = q - 1'b1;
                end
`else
                if (at_zero || out_rng) begin
                    nxt      = MAX_V;
                    force_sr = 1'b1;
                end else begin
                    nxt = q - 1'b1;
                end
`endif
            end
        end

        tc = en & ~load & ~clr & ~pr & (up ? at_max : at_zero);
    end

    always_comb begin
        j_v = '0;
        k_v = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {j_v[i], k_v[i]} = force_sr ? jk_force(nxt[i]) : jk_encode(q[i], nxt[i]);
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .clr (clr),
            .j   (j_v[gi]),
            .k   (k_v[gi]),
            .q   (q[gi]),
            .qn  (qn[gi])
        );
    end

endmodule

// File: tb/tb_jk_updown_counter.sv
// tb/tb_jk_updown_counter.sv - self-checking bench for jk_updown_counter (WIDTH=4, MODULUS=10, PRESET_VAL=3).
module tb_jk_updown_counter;

    logic       clk;
    logic       clr;
    logic       pr;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] d;
    logic [3:0] q;
    logic [3:0] qn;
    logic       tc;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       clr;
        logic       pr;
        logic       en;
        logic       up;
        logic       load;
        logic [3:0] d;
        logic [3:0] exp_q;
        logic       exp_tc;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] sb[$];

    jk_updown_counter #(
        .WIDTH      (4),
        .MODULUS    (10),
        .PRESET_VAL (3)
    ) dut (
        .clk  (clk),
        .clr  (clr),
        .pr   (pr),
        .en   (en),
        .up   (up),
        .load (load),
        .d    (d),
        .q    (q),
        .qn   (qn),
        .tc   (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void add(input logic c, input logic p, input logic e, input logic u,
                                input logic l, input logic [3:0] dv, input logic [3:0] eq,
                                input logic et);
        vec_t v;
        v.clr = c; v.pr = p; v.en = e; v.up = u; v.load = l; v.d = dv;
        v.exp_q = eq; v.exp_tc = et;
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v, input int idx);
        logic [3:0] exp;
        @(negedge clk);
        clr = v.clr; pr = v.pr; en = v.en; up = v.up; load = v.load; d = v.d;
        #1;
        checks++;
        if (tc !== v.exp_tc) begin
            errors++;
            $display("FAIL tc[%0d]: got %b expected %b", idx, tc, v.exp_tc);
        end
        sb.push_back(v.exp_q);
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        checks++;
        if (q !== exp) begin
            errors++;
            $display("FAIL q[%0d]: got %0d expected %0d", idx, q, exp);
        end
        checks++;
        if (qn !== ~exp) begin
            errors++;
            $display("FAIL qn[%0d]: got %h expected %h", idx, qn, ~exp);
        end
    endtask

    initial begin
        clr = 1'b0; pr = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; d = '0;

        // Reset held two cycles, then clr cutting into a running count.
        add(1, 0, 1, 1, 0, 4'd0, 4'd0, 1'b0);
        add(1, 0, 1, 1, 0, 4'd0, 4'd0, 1'b0);
        add(0, 0, 1, 1, 0, 4'd0, 4'd1, 1'b0);
        add(0, 0, 1, 1, 0, 4'd0, 4'd2, 1'b0);
        add(0, 0, 1, 1, 0, 4'd0, 4'd3, 1'b0);
        add(1, 0, 1, 1, 0, 4'd0, 4'd0, 1'b0);
        // Priority: clr > pr > load, and load clamps to MODULUS-1.
        add(1, 1, 0, 1, 1, 4'd5, 4'd0, 1'b0);
        add(0, 1, 0, 1, 1, 4'd5, 4'd3, 1'b0);
        add(0, 0, 0, 1, 1, 4'd12, 4'd9, 1'b0);
        add(0, 0, 1, 1, 1, 4'd4, 4'd4, 1'b0);
        // Hold for three cycles.
        add(0, 0, 0, 1, 0, 4'd0, 4'd4, 1'b0);
        add(0, 0, 0, 0, 0, 4'd0, 4'd4, 1'b0);
        add(0, 0, 0, 1, 0, 4'd0, 4'd4, 1'b0);
`ifdef JK_CNT_SATURATE_EN
        add(0, 0, 0, 1, 1, 4'd7, 4'd7, 1'b0);
        add(0, 0, 1, 1, 0, 4'd0, 4'd8, 1'b0);
        add(0, 0, 1, 1, 0, 4'd0, 4'd9, 1'b0);
        add(0, 0, 1, 1, 0, 4'd0, 4'd9, 1'b1);
        add(0, 0, 1, 1, 0, 4'd0, 4'd9, 1'b1);
        add(0, 0, 1, 1, 0, 4'd0, 4'd9, 1'b1);
        add(0, 0, 0, 0, 1, 4'd1, 4'd1, 1'b0);
        add(0, 0, 1, 0, 0, 4'd0, 4'd0, 1'b0);
        add(0, 0, 1, 0, 0, 4'd0, 4'd0, 1'b1);
        add(0, 0, 1, 0, 0, 4'd0, 4'd0, 1'b1);
`else
        add(0, 0, 0, 1, 1, 4'd0, 4'd0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            add(0, 0, 1, 1, 0, 4'd0, 4'((i + 1) % 10), (i % 10) == 9);
        end
        add(0, 0, 0, 0, 1, 4'd2, 4'd2, 1'b0);
        add(0, 0, 1, 0, 0, 4'd0, 4'd1, 1'b0);
        add(0, 0, 1, 0, 0, 4'd0, 4'd0, 1'b0);
        add(0, 0, 1, 0, 0, 4'd0, 4'd9, 1'b1);
        add(0, 0, 1, 0, 0, 4'd0, 4'd8, 1'b0);
`endif

        foreach (vecs[i]) apply(vecs[i], i);

        // Direction flipped every cycle around 4: expect 5,4,5,4,...
        begin
            vec_t v;
            v.clr = 0; v.pr = 0; v.load = 1; v.en = 0; v.up = 0; v.d = 4'd4;
            v.exp_q = 4'd4; v.exp_tc = 1'b0;
            apply(v, 100);
            for (int i = 0; i < 6; i++) begin
                v.load  = 0;
                v.en    = 1;
                v.up    = (i % 2 == 0);
                v.exp_q = v.up ? 4'd5 : 4'd4;
                apply(v, 101 + i);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
